rot_amount_detector: RTL
========================

Name: rot_amount_detector

Overview:
- Inverse of the team's 8-bit barrel rotator. Given a reference word and a target word, it finds the minimal rotation (amount k, direction dir) that maps reference to target.
- Works iteratively: one 1-bit left rotation and one compare per clock.
- Sits beside the barrel rotator in the datapath. Typical uses are alignment recovery and self-check of rotator outputs.
- dir convention matches the rotator: dir=1 is left, dir=0 is right.

Parameters:
- WIDTH, 8, data word width in bits; must be even and at least 4.
- KW, 4, width of the k output; must be at least clog2(WIDTH)+1.

Ports:
- clk  input  1  single clock; all flops rise-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  high only in IDLE.
- ref_in  input  WIDTH  reference word; captured on accept.
- tgt_in  input  WIDTH  target word; captured on accept.
- res_valid  output  1  result valid; held high until consumed.
- res_ready  input  1  result consumer ready.
- found  output  1  a rotation mapping ref to tgt exists.
- k  output  KW  rotation magnitude, 0..WIDTH/2.
- dir  output  1  1 = rotate left, 0 = rotate right.

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: in_ready=1, res_valid=0, found=0, k=0, dir=1. FSM goes to IDLE and all internal registers clear.
- FSM states: IDLE, SEARCH, DONE.
- IDLE:
  - Request accepted on any edge where in_valid and in_ready are both high.
  - On accept: cur<=ref_in, tgt<=tgt_in, cnt<=0, go to SEARCH.
- SEARCH (in_ready=0), once per cycle:
  - If cur==tgt and no match has been recorded yet, record m=cnt and set found.
  - Otherwise cur<=rotl(cur,1) and cnt<=cnt+1.
  - Leave SEARCH when a match is recorded (see Optional Feature) or when cnt==WIDTH-1 completes its compare. Then go to DONE.
- Folding m into k and dir:
  - If m <= WIDTH/2: dir=1, k=m. A tie at WIDTH/2 resolves to left.
  - Otherwise: dir=0, k=WIDTH-m.
  - No match: found=0, k=0, dir=1.
- DONE:
  - res_valid=1; found, k and dir are stable.
  - On res_valid && res_ready, go to IDLE and drop res_valid on the same edge.
  - in_ready rises only on the next cycle, so there is no same-cycle restart.
- Latency from the accepting edge, with early exit:
  - res_valid rises m+1 edges later; identical words give 1.
  - No match: WIDTH edges.
- Backpressure: with res_ready low, outputs hold indefinitely.
- Inputs ref_in and tgt_in are ignored outside the accept edge.
- Reset asserted mid-SEARCH or in DONE aborts immediately to reset values; no result is emitted.
- cnt width is clog2(WIDTH)+1, so no wrap is possible before WIDTH compares.

Optional Feature:
- Macro: ROT_DET_EARLY_EXIT_EN.
- Defined: SEARCH exits on the first match, giving variable latency (m+1 edges).
- Undefined: SEARCH always runs all WIDTH compares, giving constant latency of WIDTH edges.
  - The first match is still the one recorded; later matches are ignored.
  - Results are identical to the defined case; only timing differs.

Decomposition:
- Package rot_det_pkg holds:
  - state encoding constants IDLE=2'd0, SEARCH=2'd1, DONE=2'd2;
  - DIR_LEFT=1'b1 and DIR_RIGHT=1'b0;
  - default WIDTH and KW.
- One sub-module, rot_amount_fold: combinational mapping of (m, found) to (k, dir). It is reused by the rotator's self-check logic.

Test Plan (WIDTH=8, early exit defined unless noted):
- ref=0x55, tgt=0xAA -> found=1, k=1, dir=1; res_valid 2 edges after accept.
- ref=0x01, tgt=0x80 -> m=7, found=1, k=1, dir=0; latency 8 edges.
- ref=0x0F, tgt=0xF0 -> m=4 tie, found=1, k=4, dir=1; latency 5. With macro undefined: same result, latency 8.
- ref=0x01, tgt=0x03 -> found=0, k=0, dir=1; latency 8. Then ref=0x3C, tgt=0x3C -> k=0, found=1, latency 1.
- Backpressure: hold res_ready=0 for 10 cycles -> res_valid and outputs stable, in_ready=0. A new in_valid during this time is not accepted.
- Reset mid-SEARCH: assert rst at cycle 3 of ref=0x01, tgt=0x80 -> outputs return to reset values immediately, no res_valid. A new request after reset completes normally.

Source files
------------

// File: rtl/rot_det_pkg.sv
// Shared definitions for the rotation-amount detector: state encoding,
// direction constants and default geometry.
package rot_det_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_KW    = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/rot_amount_fold.sv
// Folds a left-rotation count m (0..WIDTH-1) into the shortest (k, dir) pair;
// a tie at WIDTH/2 resolves to left, and "not found" maps to k=0, dir=left.
module rot_amount_fold
    import rot_det_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int MW    = $clog2(DEF_WIDTH) + 1,
    parameter int KW    = DEF_KW
) (
    input  logic [MW-1:0] i_m,
    input  logic          i_found,
    output logic [KW-1:0] o_k,
    output logic          o_dir
);

    logic [KW-1:0] w_m_ext;

    assign w_m_ext = KW'(i_m);

    // NOTE: both outputs get a default before any branch so no latch is inferred.
    always_comb begin
        o_k   = '0;
        o_dir = DIR_LEFT;
        if (i_found) begin
            if (w_m_ext <= KW'(WIDTH / 2)) begin
                o_k   = w_m_ext;
                o_dir = DIR_LEFT;
            end else begin
                o_k   = KW'(WIDTH) - w_m_ext;
                o_dir = DIR_RIGHT;
            end
        end
    end

endmodule

// File: rtl/rot_amount_detector.sv
// Iterative search for the minimal rotation mapping ref_in onto tgt_in.
// Define ROT_DET_EARLY_EXIT_EN to leave SEARCH on the first match.
module rot_amount_detector
    import rot_det_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int KW    = DEF_KW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ref_in,
    input  logic [WIDTH-1:0] tgt_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             found,
    output logic [KW-1:0]    k,
    output logic             dir
);

    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_cur;
    logic [WIDTH-1:0] r_tgt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    r_m;
    logic             r_found;

    logic w_accept;
    logic w_match;
    logic w_last;
    logic w_exit;

    assign w_accept = in_valid && in_ready;
    assign w_match  = (r_cur == r_tgt) && !r_found;
    assign w_last   = (r_cnt == LAST);

`ifdef ROT_DET_EARLY_EXIT_EN
    assign w_exit = w_match || w_last;
`else
    assign w_exit = w_last;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        res_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (w_accept) w_next_state = SEARCH;
            end
            SEARCH: begin
                if (w_exit) w_next_state = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // The counter advances every SEARCH cycle, so the full sweep is exactly
    // WIDTH compares; once r_found is set, later matches are masked off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur   <= '0;
            r_tgt   <= '0;
            r_cnt   <= '0;
            r_m     <= '0;
            r_found <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cur   <= ref_in;
                        r_tgt   <= tgt_in;
                        r_cnt   <= '0;
                        r_m     <= '0;
                        r_found <= 1'b0;
                    end
                end
                SEARCH: begin
                    if (w_match) begin
                        r_m     <= r_cnt;
                        r_found <= 1'b1;
                    end
                    r_cur <= {r_cur[WIDTH-2:0], r_cur[WIDTH-1]};
                    r_cnt <= r_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    rot_amount_fold #(
        .WIDTH (WIDTH),
        .MW    (CW),
        .KW    (KW)
    ) u_fold (
        .i_m     (r_m),
        .i_found (r_found),
        .o_k     (k),
        .o_dir   (dir)
    );

    assign found = r_found;

endmodule
